dmem_access_ctrl: RTL and testbench

- Data-memory access controller directly downstream of the MEM stage; sits between the MEM-stage memory port and a variable-latency data memory/bus.
- Consumes the MEM stage's address (ALU result), store data, byte-write mask and load/store intent; issues a req/gnt/rvalid transaction; returns the raw word that the MEM stage's loader consumes.
- Asserts a pipeline stall until the access completes; flags a timeout fault.

---
 rtl/dmem_access_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : MEM-stage data-memory access controller. Runs one req/gnt/rvalid
//            transaction per load/store, stalls the pipeline until it completes,
//            and raises a one-cycle fault when the memory does not answer in time.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_load,
    input  logic                    req_store,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic                    flush,
    output logic                    stall,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_valid,
    output logic                    fault,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int c_BE_W  = DATA_WIDTH / 8;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_SAT  = c_CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_REQ    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_R = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic                  r_memReq;
    logic                  r_memWe;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic [c_BE_W-1:0]     r_memBe;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdataValid;
    logic                  r_fault;
    logic                  r_discard;
    logic [c_CNT_W-1:0]    r_count;

    logic w_reqPresent;
    logic w_isWrite;
    logic w_tmoHit;
    logic w_stall;
    logic w_launch;
    logic w_busy;
    logic w_accept;
    logic w_drop;
    logic w_capture;
    logic w_timeout;
    logic w_unusedAddrLsb;

    // A store with no byte lanes enabled carries no work and never reaches memory.
    assign w_reqPresent    = (req_load | (req_store & (|req_be))) & ~flush;
    assign w_isWrite       = req_store & (|req_be);
    assign w_tmoHit        = (r_count == c_TMO_LAST);
    assign w_unusedAddrLsb = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            c_ST_IDLE: begin
                if (w_reqPresent) begin
                    w_nextState = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (mem_gnt && (r_memWe || mem_rvalid)) begin
                    w_nextState = c_ST_DONE;
                end else if (mem_gnt) begin
                    w_nextState = w_tmoHit ? c_ST_DONE : c_ST_WAIT_R;
                end else if (flush) begin
                    w_nextState = c_ST_IDLE;
                end else if (w_tmoHit) begin
                    w_nextState = c_ST_DONE;
                end
            end
            c_ST_WAIT_R: begin
                if (mem_rvalid || w_tmoHit) begin
                    w_nextState = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_nextState = c_ST_IDLE;
            end
            default: begin
                w_nextState = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_stall   = 1'b0;
        w_launch  = 1'b0;
        w_busy    = 1'b0;
        w_accept  = 1'b0;
        w_drop    = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            c_ST_IDLE: begin
                w_stall  = w_reqPresent;
                w_launch = w_reqPresent;
            end
            c_ST_REQ: begin
                w_stall   = 1'b1;
                w_busy    = 1'b1;
                w_accept  = mem_gnt;
                w_drop    = ~mem_gnt & flush;
                w_capture = mem_gnt & ~r_memWe & mem_rvalid;
                // A flush before the grant wins over an expiring timeout.
                w_timeout = w_tmoHit & ~(mem_gnt & (r_memWe | mem_rvalid)) & ~(~mem_gnt & flush);
            end
            c_ST_WAIT_R: begin
                w_stall   = 1'b1;
                w_busy    = 1'b1;
                w_capture = mem_rvalid;
                w_timeout = w_tmoHit & ~mem_rvalid;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_memBe      <= '0;
            r_rdata      <= '0;
            r_rdataValid <= 1'b0;
            r_fault      <= 1'b0;
            r_discard    <= 1'b0;
            r_count      <= '0;
        end else begin
            r_rdataValid <= 1'b0;
            r_fault      <= 1'b0;
            if (w_launch) begin
                r_memReq   <= 1'b1;
                r_memWe    <= w_isWrite;
                r_memAddr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                r_memWdata <= req_wdata;
                r_memBe    <= w_isWrite ? req_be : {c_BE_W{1'b1}};
                r_count    <= '0;
                r_discard  <= 1'b0;
            end
            if (w_busy && (r_count != c_TMO_SAT)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_accept || w_drop) begin
                r_memReq <= 1'b0;
            end
            // Once granted, a killed load still has to drain its read data.
            if (w_busy && flush) begin
                r_discard <= 1'b1;
            end
            if (w_capture) begin
                r_rdata      <= mem_rdata;
                r_rdataValid <= ~(r_discard | flush);
            end
            if (w_timeout) begin
                r_fault  <= 1'b1;
                r_rdata  <= '0;
                r_memReq <= 1'b0;
            end
        end
    end

    assign stall       = w_stall;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdataValid;
    assign fault       = r_fault;
    assign mem_req     = r_memReq;
    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign mem_be      = r_memBe;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Brief    : Randomized self-checking bench for dmem_access_ctrl against a
//            per-transaction latency model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_load;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        flush;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          vecCount = 0;
    int          errCount = 0;
    logic [31:0] expRdata;

    dmem_access_ctrl #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .flush      (flush),
        .stall      (stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic driveQuiet();
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic checkCore(input logic eStall, input logic eReq, input logic eValid, input logic eFault);
        checkValue("stall", stall, eStall);
        checkValue("mem_req", mem_req, eReq);
        checkValue("rdata_valid", rdata_valid, eValid);
        checkValue("fault", fault, eFault);
        checkValue("rdata", rdata, expRdata);
    endtask

    task automatic checkResetState();
        checkCore(1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("rst_mem_we", mem_we, 32'd0);
        checkValue("rst_mem_addr", mem_addr, 32'd0);
        checkValue("rst_mem_wdata", mem_wdata, 32'd0);
        checkValue("rst_mem_be", mem_be, 32'd0);
    endtask

    // One cycle with nothing for memory to do: no request, zero-mask store,
    // or a flushed instruction; stray gnt/rvalid must be ignored.
    task automatic idleCycle(input int kind);
        @(posedge clk); #1;
        driveQuiet();
        case (kind)
            1: begin
                req_store = 1'b1;
                req_be    = 4'h0;
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            2: begin
                req_load = 1'b1;
                flush    = 1'b1;
                req_addr = $urandom;
            end
            3: begin
                req_store = 1'b1;
                req_be    = 4'($urandom_range(1, 15));
                flush     = 1'b1;
            end
            default: ;
        endcase
        mem_gnt    = 1'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        #1;
        checkCore(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One transaction: the grant arrives on the k-th REQ cycle, read data rDelay
    // cycles after it. It completes when the number of waiting cycles w stays
    // within TMO, otherwise it faults after TMO cycles.
    // mode 0: no flush; 1: flush before grant at flushAt; 2: flush while awaiting data.
    task automatic runTxn(input bit isStore, input bit both, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] word,
                          input int k, input int rDelay, input int mode, input int flushAt);
        int w;
        int last;
        int holdEnd;
        int endC;
        int grantEnd;
        bit ok;
        w        = isStore ? k : k + rDelay;
        ok       = (w <= TMO);
        last     = ok ? w : TMO;
        holdEnd  = (mode == 1) ? flushAt : last;
        endC     = holdEnd + 1;
        grantEnd = (k < last) ? k : last;
        for (int c = 0; c <= endC; c++) begin
            @(posedge clk); #1;
            driveQuiet();
            if (c <= holdEnd) begin
                req_store = isStore;
                req_load  = !isStore || both;
                req_addr  = addr;
                req_wdata = wdata;
                req_be    = isStore ? be : 4'h0;
            end else if (mode != 1) begin
                req_load  = 1'($urandom);
                req_store = 1'($urandom);
                req_be    = 4'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            flush   = (mode != 0) && (c == flushAt);
            mem_gnt = (c == k) && (c <= holdEnd);
            if (!isStore && ok && c == w) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word;
            end else if (c == 0 || c == endC || (c < k && c <= holdEnd)) begin
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
            end
            #1;
            if (c == endC && mode == 1) begin
                checkCore(1'b0, 1'b0, 1'b0, 1'b0);
            end else if (c == endC) begin
                if (!ok) begin
                    expRdata = 32'd0;
                end else if (!isStore) begin
                    expRdata = word;
                end
                checkCore(1'b0, 1'b0, ok && !isStore && mode != 2, !ok);
            end else if (c == 0) begin
                checkCore(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                checkCore(1'b1, c <= grantEnd, 1'b0, 1'b0);
                if (c <= grantEnd) begin
                    checkValue("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    checkValue("mem_we", mem_we, isStore);
                    checkValue("mem_be", mem_be, isStore ? be : 4'hF);
                    if (isStore) begin
                        checkValue("mem_wdata", mem_wdata, wdata);
                    end
                end
            end
        end
    endtask

    task automatic resetMidWait();
        @(posedge clk); #1;
        driveQuiet();
        req_load = 1'b1;
        req_addr = 32'h0000_3000;
        #1;
        checkCore(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        driveQuiet();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        expRdata   = 32'd0;
        #1;
        checkResetState();
        @(posedge clk); #1;
        driveQuiet();
        #1;
        checkCore(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit          isStore;
        bit          both;
        int          k;
        int          rDelay;
        int          mode;
        int          flushAt;
        int          sel;
        int          hi;
        logic [3:0]  be;
        driveQuiet();
        reset    = 1'b1;
        expRdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState();
        reset = 1'b0;

        runTxn(1'b1, 1'b0, 32'h0000_1006, 32'hAB00_0000, 4'b0100, 32'd0, 1, 0, 0, 0);
        runTxn(1'b0, 1'b0, 32'h0000_2000, 32'd0, 4'h0, 32'hDEAD_BEEF, 1, 3, 0, 0);
        runTxn(1'b1, 1'b0, 32'h0000_2008, 32'h1234_5678, 4'hF, 32'd0, 1, 0, 0, 0);
        runTxn(1'b0, 1'b0, 32'h0000_4000, 32'd0, 4'h0, 32'h5555_AAAA, 99, 0, 0, 0);
        resetMidWait();
        runTxn(1'b0, 1'b0, 32'h0000_3004, 32'd0, 4'h0, 32'h0BAD_CAFE, 2, 1, 0, 0);
        runTxn(1'b0, 1'b0, 32'h0000_5000, 32'd0, 4'h0, 32'h7777_1111, 3, 0, 1, 1);
        runTxn(1'b0, 1'b0, 32'h0000_6000, 32'd0, 4'h0, 32'h9999_2222, 1, 3, 2, 2);
        idleCycle(1);

        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) idleCycle(int'($urandom_range(0, 3)));
            isStore = 1'($urandom_range(0, 1));
            both    = isStore && ($urandom_range(0, 3) == 0);
            k       = $urandom_range(1, TMO + 2);
            rDelay  = $urandom_range(0, 4);
            be      = 4'($urandom_range(1, 15));
            mode    = 0;
            flushAt = 0;
            sel     = $urandom_range(0, 5);
            if (sel == 0 && k >= 2) begin
                hi      = (k - 1 < TMO - 1) ? k - 1 : TMO - 1;
                mode    = 1;
                flushAt = $urandom_range(1, hi);
            end else if (sel == 1 && !isStore && rDelay >= 2 && k + rDelay <= TMO) begin
                mode    = 2;
                flushAt = $urandom_range(k + 1, k + rDelay - 1);
            end
            runTxn(isStore, both, $urandom, $urandom, be, $urandom, k, rDelay, mode, flushAt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
`default_nettype wire
